// File: rtl/axi_4_lite_arb.sv
// Round-robin arbiter that serialises N_REQ single-word requesters onto one AXI4-Lite master port.
// Define AXI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; the default build is round-robin.
// state          | meaning
// IDLE           | waiting for REQ_VALID, picks winner
// RD_ADDR        | ARVALID up until ARREADY
// RD_DATA        | RREADY up until RVALID
// WR_ADDR_DATA   | AWVALID/WVALID up, each drops on its own handshake
// WR_RESP        | BREADY up until BVALID
// DONE           | one-cycle REQ_ACK to the granted requester
`timescale 1ns/1ps
module axi_4_lite_arb #(
    parameter int N_REQ              = 2,
    parameter int GRANT_W            = 1,
    parameter int C_AXI_ADDR_WIDTH   = 32,
    parameter int C_AXI_DATA_WIDTH   = 32,
    parameter int C_AXI_STROBE_WIDTH = 4
) (
    input  logic                                  M_AXI_ACLK,
    input  logic                                  M_AXI_ARESET,
    input  logic [N_REQ-1:0]                      REQ_VALID,
    input  logic [N_REQ-1:0]                      REQ_WRITE,
    input  logic [N_REQ*C_AXI_ADDR_WIDTH-1:0]     REQ_ADDR,
    input  logic [N_REQ*C_AXI_DATA_WIDTH-1:0]     REQ_WDATA,
    input  logic [N_REQ*C_AXI_STROBE_WIDTH-1:0]   REQ_WSTRB,
    output logic [N_REQ-1:0]                      REQ_ACK,
    output logic [C_AXI_DATA_WIDTH-1:0]           REQ_RDATA,
    output logic [1:0]                            REQ_RESP,
    output logic [GRANT_W-1:0]                    GRANT_ID,
    output logic                                  BUSY,
    output logic                                  M_AXI_AWVALID,
    input  logic                                  M_AXI_AWREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]           M_AXI_AWADDR,
    output logic [2:0]                            M_AXI_AWPROT,
    output logic                                  M_AXI_WVALID,
    input  logic                                  M_AXI_WREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]           M_AXI_WDATA,
    output logic [C_AXI_STROBE_WIDTH-1:0]         M_AXI_WSTRB,
    input  logic                                  M_AXI_BVALID,
    output logic                                  M_AXI_BREADY,
    input  logic [1:0]                            M_AXI_BRESP,
    output logic                                  M_AXI_ARVALID,
    input  logic                                  M_AXI_ARREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]           M_AXI_ARADDR,
    output logic [2:0]                            M_AXI_ARPROT,
    input  logic                                  M_AXI_RVALID,
    output logic                                  M_AXI_RREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]           M_AXI_RDATA,
    input  logic [1:0]                            M_AXI_RRESP
);
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int SW = C_AXI_STROBE_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR_DATA, S_WR_RESP, S_DONE
    } state_t;

    state_t             state_q;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q;
    logic [DW-1:0]      rdata_q, wdata_q;
    logic [1:0]         resp_q;
    logic               busy_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [AW-1:0]      awaddr_q, araddr_q;
    logic [SW-1:0]      wstrb_q;
    logic               found, sel_write, aw_done, w_done;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic [SW-1:0]      sel_wstrb;
    int                 scan_idx;
`ifndef AXI_ARB_FIXED_PRIO_EN
    logic [GRANT_W-1:0] ptr_q;
`endif

    // Scan order starts at the pointer (or index 0 in fixed-priority builds); first set bit wins.
    always_comb begin
        grant_d  = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
            scan_idx = k;
`else
            scan_idx = (int'(ptr_q) + k) % N_REQ;
`endif
            if (!found && |(REQ_VALID & (N_REQ'(1) << scan_idx))) begin
                found   = 1'b1;
                grant_d = GRANT_W'(scan_idx);
            end
        end
    end

    assign sel_write = |(REQ_WRITE & (N_REQ'(1) << grant_d));
    assign sel_addr  = AW'(REQ_ADDR  >> (int'(grant_d) * AW));
    assign sel_wdata = DW'(REQ_WDATA >> (int'(grant_d) * DW));
    assign sel_wstrb = SW'(REQ_WSTRB >> (int'(grant_d) * SW));
    assign aw_done   = !awvalid_q || M_AXI_AWREADY;
    assign w_done    = !wvalid_q  || M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            busy_q    <= 1'b0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
            ptr_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (found) begin
                    grant_q <= grant_d;
                    busy_q  <= 1'b1;
`ifndef AXI_ARB_FIXED_PRIO_EN
                    ptr_q   <= (int'(grant_d) == N_REQ - 1) ? '0 : grant_d + 1'b1;
`endif
                    if (sel_write) begin
                        awaddr_q  <= sel_addr;
                        wdata_q   <= sel_wdata;
                        wstrb_q   <= sel_wstrb;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_WR_ADDR_DATA;
                    end else begin
                        araddr_q  <= sel_addr;
                        arvalid_q <= 1'b1;
                        state_q   <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: if (M_AXI_ARREADY) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= S_RD_DATA;
                end
                S_RD_DATA: if (M_AXI_RVALID) begin
                    rready_q <= 1'b0;
                    rdata_q  <= M_AXI_RDATA;
                    resp_q   <= M_AXI_RRESP;
                    ack_q    <= N_REQ'(1) << grant_q;
                    state_q  <= S_DONE;
                end
                S_WR_ADDR_DATA: begin
                    if (M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: if (M_AXI_BVALID) begin
                    bready_q <= 1'b0;
                    resp_q   <= M_AXI_BRESP;
                    ack_q    <= N_REQ'(1) << grant_q;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign REQ_ACK       = ack_q;
    assign REQ_RDATA     = rdata_q;
    assign REQ_RESP      = resp_q;
    assign GRANT_ID      = grant_q;
    assign BUSY          = busy_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = rready_q;
endmodule
